// File: rtl/bus_req_queue_if.sv
// Bus request queue handshake bundle: agent requests, arbitration grants,
// releases, and the queue/ownership status returned to the bus.
// The release vector is named rel because release is a reserved word.
interface bus_req_queue_if;
    logic [8:0] req;
    logic [8:0] grant;
    logic [8:0] rel;
    logic [3:0] sender;
    logic       req_ready;
    logic       owner_valid;
    logic [3:0] owner;
    logic [8:0] pending;
    logic [3:0] count;
    logic       proto_err;

    // Agents and the arbitration unit drive requests, grants and releases.
    modport master (
        output req, grant, rel,
        input  sender, req_ready, owner_valid, owner, pending, count, proto_err
    );

    // The queue consumes them and reports its state.
    modport slave (
        input  req, grant, rel,
        output sender, req_ready, owner_valid, owner, pending, count, proto_err
    );
endinterface

// File: rtl/bus_req_queue.sv
// Bus request queue: nine agents (IDs 0..8, vector bit 8-ID) move through
// IDLE -> WAIT -> QUEUED -> OWNER. WAIT agents enter a 16-entry FIFO one per
// cycle (lowest ID first); the head is offered to the arbiter while the bus
// is free, and a matching grant hands the bus to it until it releases.
module bus_req_queue (
    input  logic       clk,
    input  logic       clr,
    bus_req_queue_if.slave bus
);
    localparam int N = 9;

    typedef enum logic [1:0] {IDLE, WAIT, QUEUED, OWNER} agent_state_t;

    agent_state_t state     [N];
    agent_state_t state_nxt [N];

    logic [3:0] fifo_mem [16];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [3:0] count;

    logic [3:0] owner, owner_nxt;
    logic       owner_valid, owner_valid_nxt;
    logic       proto_err, proto_err_nxt;

    logic       push;
    logic [3:0] push_id;
    logic       pop;
    logic [3:0] sender;
    logic [8:0] sender_mask;
    logic [8:0] owner_mask;
    logic       req_ready;
    logic       grant_err;
    logic       release_hit;

    assign sender      = (count != 4'd0) ? fifo_mem[rd_ptr] : 4'h0;
    assign req_ready   = (count != 4'd0) && !owner_valid;
    assign sender_mask = 9'h100 >> sender;
    assign owner_mask  = 9'h100 >> owner;

    // A grant is only valid when it is exactly the head agent's bit while the
    // bus is free; anything else is a protocol error with no grant effect.
    assign pop         = req_ready && (bus.grant == sender_mask);
    assign grant_err   = (|bus.grant) && !pop;
    assign release_hit = owner_valid && |(bus.rel & owner_mask);

    // Pick the lowest-ID agent currently waiting for a FIFO slot.
    always_comb begin
        push    = 1'b0;
        push_id = 4'h0;
        for (int k = N - 1; k >= 0; k--) begin
            if (state[k] == WAIT) begin
                push    = 1'b1;
                push_id = 4'(k);
            end
        end
    end

    // Next agent states, owner and error flag; the push, pop and release
    // targets are in WAIT, QUEUED and OWNER respectively, so never collide.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        owner_nxt       = owner;
        owner_valid_nxt = owner_valid;
        proto_err_nxt   = proto_err | grant_err;
        for (int k = 0; k < N; k++) begin
            state_nxt[k] = state[k];
            if (state[k] == IDLE && bus.req[N - 1 - k])
                state_nxt[k] = WAIT;
        end
        if (push)
            state_nxt[push_id] = QUEUED;
        if (pop) begin
            state_nxt[sender] = OWNER;
            owner_nxt         = sender;
            owner_valid_nxt   = 1'b1;
        end
        if (release_hit) begin
            state_nxt[owner] = IDLE;
            owner_nxt        = 4'h0;
            owner_valid_nxt  = 1'b0;
        end
    end

    // Register agent states, ownership and the sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!clr) begin
            for (int k = 0; k < N; k++) state[k] <= IDLE;
            owner       <= 4'h0;
            owner_valid <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) state[k] <= state_nxt[k];
            owner       <= owner_nxt;
            owner_valid <= owner_valid_nxt;
            proto_err   <= proto_err_nxt;
        end
    end

    // Write pushed IDs into the FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates every read, so stale
        // entries are never observed.
        if (clr && push)
            fifo_mem[wr_ptr] <= push_id;
    end

    // Advance pointers (natural 4-bit wrap) and track occupancy.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr <= 4'h0;
            rd_ptr <= 4'h0;
            count  <= 4'h0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;
            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Per-agent busy flags in bus bit order.
    always_comb begin
        bus.pending = '0;
        for (int k = 0; k < N; k++)
            bus.pending[N - 1 - k] = (state[k] != IDLE);
    end

    assign bus.sender      = sender;
    assign bus.req_ready   = req_ready;
    assign bus.owner_valid = owner_valid;
    assign bus.owner       = owner;
    assign bus.count       = count;
    assign bus.proto_err   = proto_err;
endmodule

// File: tb/tb_bus_req_queue.sv
// Directed self-checking bench for bus_req_queue.
module tb_bus_req_queue;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bus_req_queue_if bus ();

    bus_req_queue dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Agent ID -> bus vector bit mask (ID 0 is bit 8).
    function automatic logic [8:0] m(input int id);
        logic [8:0] one;
        one = 9'h100;
        return one >> id;
    endfunction

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},  16'(bus.count),       16'h0);
        check({tag, "_sender"}, 16'(bus.sender),      16'h0);
        check({tag, "_ready"},  16'(bus.req_ready),   16'h0);
        check({tag, "_ovalid"}, 16'(bus.owner_valid), 16'h0);
        check({tag, "_owner"},  16'(bus.owner),       16'h0);
        check({tag, "_pend"},   16'(bus.pending),     16'h0);
        check({tag, "_perr"},   16'(bus.proto_err),   16'h0);
    endtask

    initial begin
        bus.req   = '0;
        bus.grant = '0;
        bus.rel   = '0;

        // Reset
        tick(); tick();
        clr = 1'b1;
        check_reset_outputs("rst");

        // Single DE request: WAIT at first edge, queued at the next
        bus.req = 9'b001000000;
        tick();
        bus.req = '0;
        check("de_pend",      16'(bus.pending),   16'h040);
        check("de_cnt_wait",  16'(bus.count),     16'h0);
        tick();
        check("de_cnt",       16'(bus.count),     16'h1);
        check("de_sender",    16'(bus.sender),    16'h2);
        check("de_ready",     16'(bus.req_ready), 16'h1);

        // Grant and release DE
        bus.grant = m(2);
        tick();
        bus.grant = '0;
        check("de_owner",     16'(bus.owner),       16'h2);
        check("de_ovalid",    16'(bus.owner_valid), 16'h1);
        check("de_ready_own", 16'(bus.req_ready),   16'h0);
        check("de_cnt_own",   16'(bus.count),       16'h0);
        bus.rel = m(2);
        tick();
        bus.rel = '0;
        check("de_rel_ov",    16'(bus.owner_valid), 16'h0);
        check("de_rel_owner", 16'(bus.owner),       16'h0);
        check("de_rel_pend",  16'(bus.pending),     16'h0);

        // All nine agents at once: one push per edge, lowest ID first
        bus.req = 9'h1FF;
        tick();
        bus.req = '0;
        check("all_pend",  16'(bus.pending), 16'h1FF);
        check("all_cnt0",  16'(bus.count),   16'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("all_cnt%0d", i + 1), 16'(bus.count), 16'(i + 1));
        end
        tick();
        check("all_cnt_max", 16'(bus.count), 16'h9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("all_head%0d", i), 16'(bus.sender), 16'(i));
            bus.grant = m(i);
            tick();
            bus.grant = '0;
            check($sformatf("all_own%0d", i), 16'(bus.owner), 16'(i));
            bus.rel = m(i);
            tick();
            bus.rel = '0;
        end
        check("all_cnt_end",  16'(bus.count),     16'h0);
        check("all_pend_end", 16'(bus.pending),   16'h0);
        check("all_perr",     16'(bus.proto_err), 16'h0);

        // Push and pop on the same edge; release beats a same-edge request
        bus.req = m(2);
        tick(); tick();
        bus.req = m(1);
        tick();
        bus.req = '0;
        bus.grant = m(2);
        tick();
        bus.grant = '0;
        check("pp_cnt",    16'(bus.count),  16'h1);
        check("pp_sender", 16'(bus.sender), 16'h1);
        check("pp_owner",  16'(bus.owner),  16'h2);
        bus.rel = m(2);
        bus.req = m(2);
        tick();
        bus.rel = '0;
        bus.req = '0;
        check("rr_pend",   16'(bus.pending), 16'(m(1)));
        tick();
        check("rr_cnt",    16'(bus.count),   16'h1);
        bus.grant = m(1);
        tick();
        bus.grant = '0;
        bus.rel = m(1);
        tick();
        bus.rel = '0;
        check("rr_clean",  16'(bus.pending), 16'h0);

        // Protocol error: IE owns, DO queued; grant[0] (DMA) and a double grant
        bus.req = m(0) | m(3);
        tick();
        bus.req = '0;
        tick(); tick();
        bus.grant = m(0);
        tick();
        bus.grant = '0;
        check("pe_owner0", 16'(bus.owner),  16'h0);
        check("pe_sender", 16'(bus.sender), 16'h3);
        bus.grant = 9'b000000001;
        tick();
        bus.grant = '0;
        check("pe_err",    16'(bus.proto_err),   16'h1);
        check("pe_ovalid", 16'(bus.owner_valid), 16'h1);
        check("pe_owner",  16'(bus.owner),       16'h0);
        check("pe_cnt",    16'(bus.count),       16'h1);
        bus.rel = m(0);
        tick();
        bus.rel = '0;
        bus.grant = m(3) | m(5);
        tick();
        bus.grant = '0;
        check("pe_dbl_ov",  16'(bus.owner_valid), 16'h0);
        check("pe_dbl_cnt", 16'(bus.count),       16'h1);
        bus.grant = m(3);
        tick();
        bus.grant = '0;
        bus.rel = m(3);
        tick();
        bus.rel = '0;
        check("pe_sticky", 16'(bus.proto_err), 16'h1);
        check("pe_idle",   16'(bus.pending),   16'h0);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        check("pe_clr",    16'(bus.proto_err), 16'h0);

        // Twenty B3 round trips, wrapping both pointers
        for (int i = 0; i < 20; i++) begin
            bus.req = m(7);
            tick();
            bus.req = '0;
            tick();
            check($sformatf("b3_sender%0d", i), 16'(bus.sender),    16'h7);
            check($sformatf("b3_ready%0d", i),  16'(bus.req_ready), 16'h1);
            bus.grant = m(7);
            tick();
            bus.grant = '0;
            bus.rel = m(7);
            tick();
            bus.rel = '0;
            check($sformatf("b3_cnt%0d", i),    16'(bus.count),     16'h0);
        end
        check("b3_perr", 16'(bus.proto_err), 16'h0);

        // Mid-operation reset with IO and DO queued and IE owning
        bus.req = m(0) | m(1) | m(3);
        tick();
        bus.req = '0;
        tick(); tick(); tick();
        check("mr_cnt3",  16'(bus.count), 16'h3);
        bus.grant = m(0);
        tick();
        bus.grant = '0;
        check("mr_cnt2",  16'(bus.count), 16'h2);
        check("mr_owner", 16'(bus.owner_valid), 16'h1);
        clr = 1'b0;
        bus.grant = m(1);
        bus.req = 9'h1FF;
        tick();
        clr = 1'b1;
        bus.grant = '0;
        bus.req = '0;
        check_reset_outputs("mr");
        bus.grant = m(1);
        tick();
        bus.grant = '0;
        check("mr_err",   16'(bus.proto_err),   16'h1);
        check("mr_cnt0",  16'(bus.count),       16'h0);
        check("mr_ov0",   16'(bus.owner_valid), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
